ps2_receiver: RTL

PS2_RECEIVER -- requirements
Module: ps2_receiver

---
 rtl/ps2_receiver.sv | 139 +++++++++++++
 1 files changed

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host receiver: synchronises and de-glitches the PS/2 clock,
// deserialises 11-bit frames and reports good bytes, parity errors and framing/timeout errors.
module ps2_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       rst_x,
  input  logic       i_ps2c,
  input  logic       i_ps2d,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_parity_err,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int          FCNT_W  = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);
  localparam logic [13:0] TO_LIMIT = 14'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]        c_sync;
  logic [1:0]        d_sync;
  logic              ps2c_s;
  logic              ps2d_s;
  logic              filt;
  logic [FCNT_W-1:0] fcnt;
  logic              fall_edge;

  state_t            state;
  logic [2:0]        bit_cnt;
  logic [7:0]        shreg;
  logic              par_bit;
  logic [13:0]       tcnt;

  assign ps2c_s = c_sync[1];
  assign ps2d_s = d_sync[1];

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  // Reset drives the synchronisers to the idle-high level so no false edge follows release.
  always_ff @(posedge clk) begin
    if (!rst_x) begin
      c_sync <= 2'b11;
      d_sync <= 2'b11;
    end else begin
      c_sync <= {c_sync[0], i_ps2c};
      d_sync <= {d_sync[0], i_ps2d};
    end
  end

  // Filtered clock flips after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk) begin
    if (!rst_x) begin
      filt <= 1'b1;
      fcnt <= '0;
    end else if (ps2c_s == filt) begin
      fcnt <= '0;
    end else if (fcnt == FCNT_W'(FILTER_LEN - 1)) begin
      filt <= ps2c_s;
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end

  // High in the very cycle the filtered clock is about to go 1->0.
  assign fall_edge = filt & ~ps2c_s & (fcnt == FCNT_W'(FILTER_LEN - 1));

  always_ff @(posedge clk) begin
    if (!rst_x) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shreg        <= '0;
      par_bit      <= 1'b0;
      tcnt         <= '0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;

      if (state == IDLE || fall_edge) tcnt <= '0;
      else                            tcnt <= tcnt + 14'd1;

      case (state)
        IDLE: begin
          if (fall_edge && !ps2d_s) begin
            state   <= DATA;
            bit_cnt <= '0;
            shreg   <= '0;
          end
        end
        DATA: begin
          if (fall_edge) begin
            shreg   <= {ps2d_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
        end
        PARITY: begin
          if (fall_edge) begin
            par_bit <= ps2d_s;
            state   <= STOP;
          end
        end
        STOP: begin
          if (fall_edge) begin
            state <= IDLE;
            if (!ps2d_s) begin
              o_frame_err <= 1'b1;
            end else if (!(^{shreg, par_bit})) begin
              o_parity_err <= 1'b1;
            end else begin
              o_data  <= shreg;
              o_valid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // A stalled frame is abandoned; a simultaneous edge takes priority.
      if (state != IDLE && !fall_edge && tcnt == TO_LIMIT) begin
        state       <= IDLE;
        tcnt        <= '0;
        shreg       <= '0;
        o_frame_err <= 1'b1;
      end
    end
  end

  assign o_busy = (state != IDLE);

endmodule
